// File: rtl/pll_dri_reconfig_ctrl_if.sv
// Host command/response channel of the PLL DRI reconfiguration controller.
// master = fabric host, slave = controller.
interface pll_dri_reconfig_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [8:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [31:0] cmd_mask;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_mask,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_mask,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/pll_dri_reconfig_ctrl.sv
// DRI initiator for PolarFire PLL register read / write / masked read-modify-write.
// Optional post-write PLL lock wait is enabled by defining PLL_DRI_LOCK_WAIT_EN.
module pll_dri_reconfig_ctrl #(
  parameter int unsigned ACK_TIMEOUT  = 64,
  parameter int unsigned LOCK_TIMEOUT = 65535,
  parameter int unsigned LOCK_SETTLE  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  pll_dri_reconfig_ctrl_if.slave        host,
  output logic [10:0]                   dri_ctrl,
  output logic [32:0]                   dri_wdata,
  input  logic [32:0]                   dri_rdata,
  output logic                          dri_arst_n,
  input  logic                          pll_lock
);

  localparam int unsigned ACK_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    WR_WAIT,
`ifdef PLL_DRI_LOCK_WAIT_EN
    LOCK_WAIT,
`endif
    RESP
  } state_e;

  state_e           state;
  logic [ACK_W-1:0] ack_cnt;
  logic             rmw_q;
  logic [8:0]       addr_q;
  logic [31:0]      data_q;
  logic [31:0]      mask_q;
  logic [31:0]      merged;
  logic             ack;

  assign dri_arst_n = ~reset;
  assign ack        = dri_rdata[32];
  assign merged     = (dri_rdata[31:0] & ~mask_q) | (data_q & mask_q);

`ifdef PLL_DRI_LOCK_WAIT_EN
  localparam int unsigned SETTLE_W = (LOCK_SETTLE < 1) ? 1 : $clog2(LOCK_SETTLE + 1);
  localparam int unsigned LOCK_W   = (LOCK_TIMEOUT < 2) ? 1 : $clog2(LOCK_TIMEOUT + 1);
  logic [SETTLE_W-1:0] settle_cnt;
  logic [LOCK_W-1:0]   lock_cnt;
`else
  localparam int unsigned unused_lock_cfg = LOCK_TIMEOUT + LOCK_SETTLE;
  logic unused_lock;
  assign unused_lock = pll_lock;
`endif

  // Command sequencer; every DRI and host output is registered here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      host.cmd_ready <= 1'b1;
      host.rsp_valid <= 1'b0;
      host.rsp_err   <= 1'b0;
      host.rsp_rdata <= '0;
      host.busy      <= 1'b0;
      dri_ctrl       <= '0;
      dri_wdata      <= '0;
      ack_cnt        <= '0;
      rmw_q          <= 1'b0;
      addr_q         <= '0;
      data_q         <= '0;
      mask_q         <= '0;
`ifdef PLL_DRI_LOCK_WAIT_EN
      settle_cnt     <= '0;
      lock_cnt       <= '0;
`endif
    end else begin
      dri_ctrl       <= '0;
      host.rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (host.cmd_valid && host.cmd_ready) begin
            host.cmd_ready <= 1'b0;
            host.busy      <= 1'b1;
            addr_q         <= host.cmd_addr;
            data_q         <= host.cmd_wdata;
            mask_q         <= host.cmd_mask;
            dri_wdata      <= {1'b0, host.cmd_wdata};
            rmw_q          <= host.cmd_write && (host.cmd_mask != '1);
            // Plain writes skip the read phase; reads and RMW start with a read strobe.
            if (host.cmd_write && (host.cmd_mask == '1)) begin
              dri_ctrl <= {2'b11, host.cmd_addr};
              state    <= WR_REQ;
            end else begin
              dri_ctrl <= {2'b10, host.cmd_addr};
              state    <= RD_REQ;
            end
          end
        end
        RD_REQ: begin
          ack_cnt <= ACK_W'(ACK_TIMEOUT);
          state   <= RD_WAIT;
        end
        WR_REQ: begin
          ack_cnt <= ACK_W'(ACK_TIMEOUT);
          state   <= WR_WAIT;
        end
        RD_WAIT: begin
          if (ack) begin
            if (rmw_q) begin
              data_q    <= merged;
              dri_ctrl  <= {2'b11, addr_q};
              dri_wdata <= {1'b0, merged};
              state     <= WR_REQ;
            end else begin
              host.rsp_rdata <= dri_rdata[31:0];
              host.rsp_err   <= 1'b0;
              host.rsp_valid <= 1'b1;
              state          <= RESP;
            end
          end else if (ack_cnt <= ACK_W'(1)) begin
            host.rsp_err   <= 1'b1;
            host.rsp_valid <= 1'b1;
            state          <= RESP;
          end else begin
            ack_cnt <= ack_cnt - ACK_W'(1);
          end
        end
        WR_WAIT: begin
          if (ack) begin
            host.rsp_rdata <= data_q;
`ifdef PLL_DRI_LOCK_WAIT_EN
            settle_cnt <= SETTLE_W'(LOCK_SETTLE);
            lock_cnt   <= LOCK_W'(LOCK_TIMEOUT);
            state      <= LOCK_WAIT;
`else
            host.rsp_err   <= 1'b0;
            host.rsp_valid <= 1'b1;
            state          <= RESP;
`endif
          end else if (ack_cnt <= ACK_W'(1)) begin
            host.rsp_err   <= 1'b1;
            host.rsp_valid <= 1'b1;
            state          <= RESP;
          end else begin
            ack_cnt <= ack_cnt - ACK_W'(1);
          end
        end
`ifdef PLL_DRI_LOCK_WAIT_EN
        // Lock is ignored while the PLL settles after the register update.
        LOCK_WAIT: begin
          if (settle_cnt != '0) begin
            settle_cnt <= settle_cnt - SETTLE_W'(1);
          end else if (pll_lock) begin
            host.rsp_err   <= 1'b0;
            host.rsp_valid <= 1'b1;
            state          <= RESP;
          end else if (lock_cnt <= LOCK_W'(1)) begin
            host.rsp_err   <= 1'b1;
            host.rsp_valid <= 1'b1;
            state          <= RESP;
          end else begin
            lock_cnt <= lock_cnt - LOCK_W'(1);
          end
        end
`endif
        RESP: begin
          host.cmd_ready <= 1'b1;
          host.busy      <= 1'b0;
          state          <= IDLE;
        end
        default: begin
          host.cmd_ready <= 1'b1;
          host.busy      <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_dri_reconfig_ctrl.sv
// Directed bench for pll_dri_reconfig_ctrl with a behavioural DRI slave.
// Lock-wait cases run only when PLL_DRI_LOCK_WAIT_EN is defined.
module tb_pll_dri_reconfig_ctrl;
  localparam int unsigned ACK_T  = 8;
  localparam int unsigned LOCK_T = 100;
  localparam int unsigned SETTLE = 16;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] dri_ctrl;
  logic [32:0] dri_wdata;
  logic [32:0] dri_rdata = '0;
  logic        dri_arst_n;
  logic        pll_lock  = 1'b0;

  pll_dri_reconfig_ctrl_if host_if();

  pll_dri_reconfig_ctrl #(
    .ACK_TIMEOUT (ACK_T),
    .LOCK_TIMEOUT(LOCK_T),
    .LOCK_SETTLE (SETTLE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .host      (host_if),
    .dri_ctrl  (dri_ctrl),
    .dri_wdata (dri_wdata),
    .dri_rdata (dri_rdata),
    .dri_arst_n(dri_arst_n),
    .pll_lock  (pll_lock)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave controls (written by the stimulus only)
  int          ack_delay  = 0;
  int          lock_delay = 0;
  logic [31:0] slave_data = '0;

  // Slave state and logs (written by the slave only)
  int          ack_cd     = 0;
  bit          pend_wr    = 1'b0;
  int          wr_ack_cyc = 1 << 30;
  int          n_strobe   = 0;
  int          n_rsp      = 0;
  logic [10:0] s_ctrl [64];
  logic [32:0] s_wd   [64];
  int          s_cyc  [64];

  // DRI slave: acks ack_delay cycles after each strobe (0 = never), drives PLL lock.
  always @(negedge clk) begin
    dri_rdata = '0;
    if (reset) begin
      ack_cd = 0;
    end else if (ack_cd > 0) begin
      ack_cd--;
      if (ack_cd == 0) begin
        dri_rdata = {1'b1, slave_data};
        if (pend_wr) wr_ack_cyc = cyc;
      end
    end
    if (dri_ctrl[10]) begin
      if (n_strobe < 64) begin
        s_ctrl[n_strobe] = dri_ctrl;
        s_wd[n_strobe]   = dri_wdata;
        s_cyc[n_strobe]  = cyc;
      end
      n_strobe++;
      pend_wr = dri_ctrl[9];
      if (dri_ctrl[9]) wr_ack_cyc = 1 << 30;
      ack_cd = ack_delay;
    end
    pll_lock = (lock_delay > 0) && (cyc >= wr_ack_cyc + lock_delay);
    if (host_if.rsp_valid) n_rsp++;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int acc_cyc  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic do_cmd(input logic wr, input logic [8:0] addr, input logic [31:0] wd,
                        input logic [31:0] mk, output int waits);
    waits = 0;
    @(negedge clk);
    host_if.cmd_valid = 1'b1;
    host_if.cmd_write = wr;
    host_if.cmd_addr  = addr;
    host_if.cmd_wdata = wd;
    host_if.cmd_mask  = mk;
    while (!host_if.cmd_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    acc_cyc = cyc;
    @(negedge clk);
    host_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int budget, output int rsp_cyc);
    rsp_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (host_if.rsp_valid) begin
        rsp_cyc = cyc;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, rc, prev_rc, sb, rb;
    host_if.cmd_valid = 1'b0;
    host_if.cmd_write = 1'b0;
    host_if.cmd_addr  = '0;
    host_if.cmd_wdata = '0;
    host_if.cmd_mask  = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(host_if.cmd_ready), 64'(1));
    check("rst_rsp_valid", 64'(host_if.rsp_valid), 64'(0));
    check("rst_busy", 64'(host_if.busy), 64'(0));
    check("rst_rdata", 64'(host_if.rsp_rdata), 64'(0));
    check("rst_ctrl", 64'(dri_ctrl), 64'(0));
    check("rst_arst_n", 64'(dri_arst_n), 64'(0));
    reset = 1'b0;
    #1 check("rel_arst_n", 64'(dri_arst_n), 64'(1));

    // Read 0x012, ack 3 cycles after strobe with 0x19
    ack_delay = 3; slave_data = 32'h0000_0019;
    sb = n_strobe;
    do_cmd(1'b0, 9'h012, 32'h0, 32'h0, w);
    check("rd_accept_wait", 64'(w), 64'(0));
    check("rd_busy", 64'(host_if.busy), 64'(1));
    check("rd_ready_low", 64'(host_if.cmd_ready), 64'(0));
    wait_rsp(40, rc);
    check("rd_rdata", 64'(host_if.rsp_rdata), 64'(32'h19));
    check("rd_err", 64'(host_if.rsp_err), 64'(0));
    check("rd_ctrl", 64'(s_ctrl[sb]), 64'(11'h412));
    check("rd_req_lat", 64'(s_cyc[sb] - acc_cyc), 64'(1));
    check("rd_rsp_lat", 64'(rc - s_cyc[sb]), 64'(4));
    @(negedge clk);
    check("rd_rsp_pulse", 64'(host_if.rsp_valid), 64'(0));
    check("rd_busy_done", 64'(host_if.busy), 64'(0));
    check("rd_ready_back", 64'(host_if.cmd_ready), 64'(1));
    check("rd_nstrobe", 64'(n_strobe - sb), 64'(1));

    // Plain write
    ack_delay = 2; slave_data = 32'h0;
    sb = n_strobe;
    do_cmd(1'b1, 9'h013, 32'hA5A5_0032, 32'hFFFF_FFFF, w);
    wait_rsp(400, rc);
    check("wr_rdata", 64'(host_if.rsp_rdata), 64'(32'hA5A5_0032));
    check("wr_err", 64'(host_if.rsp_err), 64'(0));
    check("wr_ctrl", 64'(s_ctrl[sb]), 64'(11'h613));
    check("wr_wdata", 64'(s_wd[sb]), 64'(33'h0_A5A5_0032));
    check("wr_nstrobe", 64'(n_strobe - sb), 64'(1));

    // Read-modify-write
    ack_delay = 2; slave_data = 32'hFFFF_0000;
    sb = n_strobe;
    do_cmd(1'b1, 9'h020, 32'h0000_1234, 32'h0000_FFFF, w);
    wait_rsp(400, rc);
    check("rmw_nstrobe", 64'(n_strobe - sb), 64'(2));
    check("rmw_rd_ctrl", 64'(s_ctrl[sb]), 64'(11'h420));
    check("rmw_wr_ctrl", 64'(s_ctrl[sb+1]), 64'(11'h620));
    check("rmw_wr_wdata", 64'(s_wd[sb+1]), 64'(33'h0_FFFF_1234));
    check("rmw_gap", 64'(s_cyc[sb+1] - s_cyc[sb]), 64'(3));
    check("rmw_rdata", 64'(host_if.rsp_rdata), 64'(32'hFFFF_1234));
    check("rmw_err", 64'(host_if.rsp_err), 64'(0));

    // Ack timeout: never acked
    ack_delay = 0;
    sb = n_strobe;
    do_cmd(1'b0, 9'h005, 32'h0, 32'h0, w);
    wait_rsp(40, rc);
    check("to_err", 64'(host_if.rsp_err), 64'(1));
    check("to_lat", 64'(rc - s_cyc[sb]), 64'(9));
    check("to_rdata_hold", 64'(host_if.rsp_rdata), 64'(32'hFFFF_1234));
    repeat (10) @(negedge clk);
    check("to_nstrobe", 64'(n_strobe - sb), 64'(1));

    // Ack in the expiry cycle wins
    ack_delay = 8; slave_data = 32'h0000_CAFE;
    sb = n_strobe;
    do_cmd(1'b0, 9'h006, 32'h0, 32'h0, w);
    wait_rsp(40, rc);
    check("edge_err", 64'(host_if.rsp_err), 64'(0));
    check("edge_rdata", 64'(host_if.rsp_rdata), 64'(32'hCAFE));
    check("edge_lat", 64'(rc - s_cyc[sb]), 64'(9));
    prev_rc = rc;

    // Back-to-back; ack one cycle after expiry is too late
    ack_delay = 9; slave_data = 32'h0000_BEEF;
    sb = n_strobe;
    do_cmd(1'b0, 9'h007, 32'h0, 32'h0, w);
    check("b2b_wait", 64'(w), 64'(0));
    check("b2b_accept", 64'(acc_cyc - prev_rc), 64'(1));
    wait_rsp(40, rc);
    check("late_err", 64'(host_if.rsp_err), 64'(1));
    check("late_lat", 64'(rc - s_cyc[sb]), 64'(9));
    check("late_rdata_hold", 64'(host_if.rsp_rdata), 64'(32'hCAFE));
    repeat (5) @(negedge clk);
    check("late_nstrobe", 64'(n_strobe - sb), 64'(1));

    // Reset during RD_WAIT
    ack_delay = 0;
    sb = n_strobe;
    do_cmd(1'b0, 9'h008, 32'h0, 32'h0, w);
    repeat (3) @(negedge clk);
    rb = n_rsp;
    reset = 1'b1;
    #1;
    check("mid_rst_ready", 64'(host_if.cmd_ready), 64'(1));
    check("mid_rst_busy", 64'(host_if.busy), 64'(0));
    check("mid_rst_err", 64'(host_if.rsp_err), 64'(0));
    check("mid_rst_rdata", 64'(host_if.rsp_rdata), 64'(0));
    check("mid_rst_valid", 64'(host_if.rsp_valid), 64'(0));
    check("mid_rst_ctrl", 64'(dri_ctrl), 64'(0));
    check("mid_rst_wdata", 64'(dri_wdata), 64'(0));
    check("mid_rst_arst_n", 64'(dri_arst_n), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    check("abort_no_rsp", 64'(n_rsp - rb), 64'(0));
    check("abort_nstrobe", 64'(n_strobe - sb), 64'(1));
    ack_delay = 1; slave_data = 32'h0000_0077;
    sb = n_strobe;
    do_cmd(1'b0, 9'h009, 32'h0, 32'h0, w);
    wait_rsp(40, rc);
    check("post_rst_rdata", 64'(host_if.rsp_rdata), 64'(32'h77));
    check("post_rst_err", 64'(host_if.rsp_err), 64'(0));
    check("post_rst_ctrl", 64'(s_ctrl[sb]), 64'(11'h409));
    check("post_rst_lat", 64'(rc - s_cyc[sb]), 64'(2));

`ifdef PLL_DRI_LOCK_WAIT_EN
    // Lock arrives 40 cycles after the write ack
    ack_delay = 2; lock_delay = 40; slave_data = 32'h0;
    do_cmd(1'b1, 9'h030, 32'h0000_0011, 32'hFFFF_FFFF, w);
    wait_rsp(400, rc);
    check("lock_err", 64'(host_if.rsp_err), 64'(0));
    check("lock_lat", 64'(rc - wr_ack_cyc), 64'(41));
    check("lock_rdata", 64'(host_if.rsp_rdata), 64'(32'h11));
    // Lock never arrives
    lock_delay = 0;
    do_cmd(1'b1, 9'h031, 32'h0000_0022, 32'hFFFF_FFFF, w);
    wait_rsp(400, rc);
    check("lock_to_err", 64'(host_if.rsp_err), 64'(1));
    check("lock_to_lat", 64'(rc - wr_ack_cyc), 64'(1 + SETTLE + LOCK_T));
    check("lock_to_rdata", 64'(host_if.rsp_rdata), 64'(32'h22));
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
